// File: rtl/hovalaag_pkg.sv
// rtl/hovalaag_pkg.sv - shared constants for the Hovalaag input buffer
package hovalaag_pkg;

  localparam int HV_DATA_W = 12;
  localparam int HV_DEPTH  = 16;

  // Same encoding as the CPU IO_select bit
  localparam logic HV_CH1 = 1'b0;
  localparam logic HV_CH2 = 1'b1;

endpackage

// File: rtl/hovalaag_in_buffer_if.sv
// rtl/hovalaag_in_buffer_if.sv - loader/CPU side signals of the dual-channel input buffer
interface hovalaag_in_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 12
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic              wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [DATA_W-1:0] IN1;
  logic              IN1_adv;
  logic [DATA_W-1:0] IN2;
  logic              IN2_adv;
  logic [CW-1:0]     cnt1;
  logic [CW-1:0]     cnt2;
  logic              underflow1;
  logic              underflow2;

  modport master (
    output wr_en, wr_sel, wr_data, IN1_adv, IN2_adv,
    input  wr_ready, IN1, IN2, cnt1, cnt2, underflow1, underflow2
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, IN1_adv, IN2_adv,
    output wr_ready, IN1, IN2, cnt1, cnt2, underflow1, underflow2
  );
endinterface

// File: rtl/hovalaag_in_chan.sv
// rtl/hovalaag_in_chan.sv - single input channel FIFO with zero-latency head and sticky underflow
module hovalaag_in_chan
  import hovalaag_pkg::*;
#(
  parameter int DEPTH  = HV_DEPTH,
  parameter int DATA_W = HV_DATA_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [CW-1:0]     o_cnt,
  output logic              o_full,
  output logic              o_underflow
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_cnt;
  logic              r_underflow;

  logic w_empty;
  logic w_full;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(DEPTH));
  // Full is judged on the current count only, so a same-cycle pop never frees a slot
  assign w_push_ok = i_push && !w_full;
  assign w_pop_ok  = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (i_pop && w_empty) begin
        r_underflow <= 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_cnt       = r_cnt;
  assign o_full      = w_full;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/hovalaag_in_buffer.sv
// rtl/hovalaag_in_buffer.sv - dual-channel input stream buffer feeding the Hovalaag CPU
module hovalaag_in_buffer
  import hovalaag_pkg::*;
#(
  parameter int DEPTH  = HV_DEPTH,
  parameter int DATA_W = HV_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  hovalaag_in_buffer_if.slave  bus
);

  logic w_push1;
  logic w_push2;
  logic w_full1;
  logic w_full2;

  assign w_push1 = bus.wr_en && (bus.wr_sel == HV_CH1);
  assign w_push2 = bus.wr_en && (bus.wr_sel == HV_CH2);

  // Only wr_sel and counts reach wr_ready; the adv inputs never do
  assign bus.wr_ready = (bus.wr_sel == HV_CH1) ? !w_full1 : !w_full2;

  hovalaag_in_chan #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_chan1 (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .i_push      (w_push1),
    .i_data      (bus.wr_data),
    .i_pop       (bus.IN1_adv),
    .o_head      (bus.IN1),
    .o_cnt       (bus.cnt1),
    .o_full      (w_full1),
    .o_underflow (bus.underflow1)
  );

  hovalaag_in_chan #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_chan2 (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .i_push      (w_push2),
    .i_data      (bus.wr_data),
    .i_pop       (bus.IN2_adv),
    .o_head      (bus.IN2),
    .o_cnt       (bus.cnt2),
    .o_full      (w_full2),
    .o_underflow (bus.underflow2)
  );

endmodule

// File: tb/tb_hovalaag_in_buffer.sv
// tb/tb_hovalaag_in_buffer.sv - directed self-checking bench for hovalaag_in_buffer
module tb_hovalaag_in_buffer;

  logic clk;
  logic rst;
  logic clr;
  int   n_tests;
  int   n_fail;

  hovalaag_in_buffer_if #(.DEPTH(16), .DATA_W(12)) bus ();

  hovalaag_in_buffer #(.DEPTH(16), .DATA_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are changed and outputs sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.IN1_adv = 1'b0;
    bus.IN2_adv = 1'b0;
    rst         = 1'b0;
    clr         = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic push(input logic sel, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_data = 12'(data);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pop1();
    bus.IN1_adv = 1'b1;
    step();
    bus.IN1_adv = 1'b0;
  endtask

  task automatic pop2();
    bus.IN2_adv = 1'b1;
    step();
    bus.IN2_adv = 1'b0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    bus.wr_sel  = 1'b0;
    bus.wr_data = '0;
    idle();

    // Reset state
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_in1", bus.IN1, 0);
    check("rst_in2", bus.IN2, 0);
    check("rst_cnt1", bus.cnt1, 0);
    check("rst_cnt2", bus.cnt2, 0);
    check("rst_uf1", bus.underflow1, 0);
    check("rst_uf2", bus.underflow2, 0);
    check("rst_wr_ready", bus.wr_ready, 1);

    // Basic push/head/pop
    push(1'b0, 'h123);
    push(1'b0, 'h456);
    push(1'b1, 'hFFF);
    check("basic_in1", bus.IN1, 'h123);
    check("basic_cnt1", bus.cnt1, 2);
    check("basic_in2", bus.IN2, 'hFFF);
    check("basic_cnt2", bus.cnt2, 1);
    pop1();
    check("basic_in1_after_pop", bus.IN1, 'h456);
    check("basic_cnt1_after_pop", bus.cnt1, 1);

    // Fill ch1, overflow drop, drain in order
    do_clr();
    for (int i = 0; i < 16; i++) push(1'b0, i);
    bus.wr_sel = 1'b0;
    #1;
    check("full_wr_ready_ch1", bus.wr_ready, 0);
    bus.wr_sel = 1'b1;
    #1;
    check("full_wr_ready_ch2", bus.wr_ready, 1);
    check("full_cnt1", bus.cnt1, 16);
    push(1'b0, 'h0AA);
    check("drop_cnt1", bus.cnt1, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_in1_%0d", i), bus.IN1, i);
      pop1();
    end
    check("drain_in1_empty", bus.IN1, 0);
    check("drain_cnt1_empty", bus.cnt1, 0);
    check("drain_uf1", bus.underflow1, 0);

    // Underflow on ch2 is sticky until clr
    do_clr();
    pop2();
    check("uf_uf2", bus.underflow2, 1);
    check("uf_cnt2", bus.cnt2, 0);
    check("uf_in2", bus.IN2, 0);
    check("uf_uf1", bus.underflow1, 0);
    step();
    step();
    check("uf_uf2_sticky", bus.underflow2, 1);
    do_clr();
    check("uf_uf2_cleared", bus.underflow2, 0);

    // Simultaneous push and pop
    push(1'b0, 'h001);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 1'b0;
    bus.wr_data = 12'h002;
    bus.IN1_adv = 1'b1;
    step();
    idle();
    check("pp_cnt1", bus.cnt1, 1);
    check("pp_in1", bus.IN1, 'h002);
    check("pp_uf1", bus.underflow1, 0);
    pop1();
    check("pp_cnt1_empty", bus.cnt1, 0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 12'h003;
    bus.IN1_adv = 1'b1;
    step();
    idle();
    check("pp_empty_uf1", bus.underflow1, 1);
    check("pp_empty_cnt1", bus.cnt1, 1);
    check("pp_empty_in1", bus.IN1, 'h003);

    // Both adv in one cycle
    do_clr();
    push(1'b0, 'h011);
    push(1'b1, 'h022);
    bus.IN1_adv = 1'b1;
    bus.IN2_adv = 1'b1;
    step();
    idle();
    check("both_cnt1", bus.cnt1, 0);
    check("both_cnt2", bus.cnt2, 0);
    check("both_uf1", bus.underflow1, 0);
    check("both_uf2", bus.underflow2, 0);

    // Wrap-around: 40 cycles of push+pop on ch1
    do_clr();
    push(1'b0, 'h100);
    for (int i = 1; i <= 40; i++) begin
      check($sformatf("wrap_in1_%0d", i), bus.IN1, 'h100 + i - 1);
      bus.wr_en   = 1'b1;
      bus.wr_sel  = 1'b0;
      bus.wr_data = 12'('h100 + i);
      bus.IN1_adv = 1'b1;
      step();
      idle();
      check($sformatf("wrap_cnt1_%0d", i), bus.cnt1, 1);
    end
    check("wrap_uf1", bus.underflow1, 0);

    // Mid-stream reset
    do_clr();
    for (int i = 0; i < 5; i++) push(1'b0, 'h200 + i);
    for (int i = 0; i < 3; i++) push(1'b1, 'h300 + i);
    check("mid_cnt1", bus.cnt1, 5);
    check("mid_cnt2", bus.cnt2, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.wr_sel = 1'b0;
    #1;
    check("mid_rst_cnt1", bus.cnt1, 0);
    check("mid_rst_cnt2", bus.cnt2, 0);
    check("mid_rst_in1", bus.IN1, 0);
    check("mid_rst_in2", bus.IN2, 0);
    check("mid_rst_uf1", bus.underflow1, 0);
    check("mid_rst_uf2", bus.underflow2, 0);
    check("mid_rst_wr_ready", bus.wr_ready, 1);
    push(1'b0, 'h7AB);
    check("mid_push_in1", bus.IN1, 'h7AB);
    check("mid_push_cnt1", bus.cnt1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hovalaag_in_buffer.md
Name: hovalaag_in_buffer

Overview:
- Dual-channel input stream buffer that sits directly upstream of the Hovalaag CPU core.
- The host or testbench loader pushes 12-bit words tagged for channel 1 or 2.
- The block presents each channel's head word combinationally on IN1/IN2 and pops a channel when the CPU asserts IN1_adv/IN2_adv.
- It flags reads from an empty channel (underflow), because the CPU has no stall mechanism.

Parameters:
- DEPTH, 16, entries per channel; power of 2, minimum 2.
- DATA_W, 12, word width; must match the CPU datapath.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high. Flushes both channels and clears all flags.
- clr  in  1  synchronous flush of both channels and underflow flags, same effect as rst; used between test vectors.
- wr_en  in  1  push request.
- wr_sel  in  1  target channel: 0 selects channel 1, 1 selects channel 2.
- wr_data  in  DATA_W  word to push.
- wr_ready  out  1  selected channel not full; combinational from wr_sel and counts.
- IN1  out  DATA_W  channel 1 head word; 0 when empty.
- IN1_adv  in  1  CPU pops channel 1.
- IN2  out  DATA_W  channel 2 head word; 0 when empty.
- IN2_adv  in  1  CPU pops channel 2.
- cnt1  out  $clog2(DEPTH)+1  channel 1 occupancy.
- cnt2  out  $clog2(DEPTH)+1  channel 2 occupancy.
- underflow1  out  1  sticky: channel 1 was popped while empty.
- underflow2  out  1  sticky: channel 2 was popped while empty.

Behaviour:
- All state updates on posedge clk.
- rst has priority over clr; clr has priority over push/pop. Either one sets:
  - rd/wr pointers = 0,
  - counts = 0,
  - underflow flags = 0.
  - Storage contents are don't-care.
- Reset output values: IN1=IN2=0, cnt1=cnt2=0, underflow1=underflow2=0, wr_ready=1.
- Head presentation:
  - INx = mem_x[rd_ptr_x] when cnt_x != 0, else 0. Purely combinational.
  - Zero latency: the CPU samples IN on the same edge it asserts adv.
- Push accepted iff wr_en && wr_ready.
  - Writes mem[wr_ptr] of the selected channel.
  - wr_ptr increments modulo DEPTH.
  - cnt increments.
- wr_ready = (cnt of the channel selected by wr_sel) != DEPTH.
  - A push to a full channel is dropped, even if that channel is popped in the same cycle.
  - This deliberately keeps any combinational path from IN_adv out of wr_ready.
- Pop on INx_adv:
  - If cnt_x != 0: rd_ptr increments modulo DEPTH and cnt decrements.
  - If cnt_x == 0: pointers and count are unchanged and underflow_x is set. The CPU consumed 0.
- Simultaneous push and pop on the same channel:
  - cnt != 0: both take effect; cnt unchanged; head advances; new word lands at the tail.
  - cnt == 0: the pop is an underflow (flag set, CPU saw 0). The push is stored, so cnt becomes 1.
- Both adv inputs high in one cycle (not produced by the CPU, but legal here): each channel handles its own pop independently.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is decided from cnt only.
- Underflow flags stay set until rst or clr.

Decomposition:
- Shared package hovalaag_pkg:
  - HV_DATA_W = 12,
  - channel-select constants HV_CH1 = 1'b0, HV_CH2 = 1'b1 (same encoding as the CPU IO_select bit).
- Sub-module hovalaag_in_chan: single-channel FIFO with push, pop, head, cnt, full and sticky underflow.
  - Instantiated twice.
  - The top level only decodes wr_sel into per-channel push enables and muxes wr_ready.

Test Plan:
- Reset, then push 0x123, 0x456 to ch1 and 0xFFF to ch2 -> IN1=0x123, cnt1=2, IN2=0xFFF, cnt2=1. Pulse IN1_adv once -> IN1=0x456, cnt1=1.
- Push 16 words 0..15 to ch1 -> wr_ready=0 with wr_sel=0. A 17th push of 0x0AA is dropped, cnt1 stays 16. Pop 16 times -> values 0..15 in order, then IN1=0, cnt1=0.
- Empty ch2: pulse IN2_adv -> underflow2=1, cnt2=0, IN2=0. underflow1 stays 0. Flag persists until clr pulse -> underflow2=0.
- Ch1 holding 1 word (0x001): push 0x002 and pop in the same cycle -> cnt1=1, IN1=0x002. On empty ch1, push 0x003 and pop in the same cycle -> underflow1=1, cnt1=1, IN1=0x003.
- Wrap-around: repeatedly push 1 and pop 1 on ch1 for 40 cycles with an incrementing pattern -> every popped value matches the pushed sequence, cnt1 is never above 1.
- Mid-stream rst with cnt1=5, cnt2=3 -> next cycle all counts 0, IN1=IN2=0, flags 0, wr_ready=1. A subsequent push 0x7AB to ch1 -> IN1=0x7AB.
